// File: rtl/nibble_match_scanner_pkg.sv
// Shared types and default sizing for the nibble match scanner.
package nibble_match_scanner_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_IDX_W = 8;
endpackage

// File: rtl/nibble_eq.sv
// Combinational WIDTH-bit equality compare.
module nibble_eq #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);
  assign eq = (a == b);
endmodule

// File: rtl/nibble_match_scanner.sv
// Scans a valid/ready nibble stream against a stored key; reports first-match
// index and saturating match/beat counts through a valid/ack result port.
module nibble_match_scanner
  import nibble_match_scanner_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             found,
  output logic [IDX_W-1:0] first_idx,
  output logic [IDX_W-1:0] match_cnt,
  output logic [IDX_W-1:0] beat_cnt,
  output logic             overflow
);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] key;
  logic             match;

  nibble_eq #(.WIDTH(WIDTH)) u_eq (.a(in_data), .b(key), .eq(match));

  // Handshake/status outputs decode the state register only.
  assign in_ready  = (state == SCAN);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      found     <= 1'b0;
      first_idx <= '0;
      match_cnt <= '0;
      beat_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // key_load wins over start so a key and scan can't race.
          if (key_load) begin
            key <= key_in;
          end else if (start) begin
            found     <= 1'b0;
            first_idx <= '0;
            match_cnt <= '0;
            beat_cnt  <= '0;
            overflow  <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (in_valid) begin
            if (match && !found) begin
              found     <= 1'b1;
              first_idx <= beat_cnt;
            end
            if (match && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
            // Counters stick at max; overflow flags the first beat that would wrap.
            if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
            else                     overflow <= 1'b1;
            if (in_last) state <= DONE;
          end
        end
        DONE: begin
          if (res_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_match_scanner.sv
// Directed bench: driver pushes expected results, monitors compare on res_valid.
module tb_nibble_match_scanner;
  typedef struct packed {
    logic       found;
    logic [7:0] first_idx;
    logic [7:0] match_cnt;
    logic [7:0] beat_cnt;
    logic       overflow;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default sizing
  logic       key_load = 0, start = 0, in_valid = 0, in_last = 0, res_ack = 0;
  logic [3:0] key_in = 0, in_data = 0;
  logic       in_ready, busy, res_valid, found, overflow;
  logic [7:0] first_idx, match_cnt, beat_cnt;

  // Instance 2: IDX_W=2 for saturation
  logic       key_load2 = 0, start2 = 0, in_valid2 = 0, in_last2 = 0, res_ack2 = 0;
  logic [3:0] key_in2 = 0, in_data2 = 0;
  logic       in_ready2, busy2, res_valid2, found2, overflow2;
  logic [1:0] first_idx2, match_cnt2, beat_cnt2;

  nibble_match_scanner #(.WIDTH(4), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .busy(busy), .res_valid(res_valid), .res_ack(res_ack), .found(found),
    .first_idx(first_idx), .match_cnt(match_cnt), .beat_cnt(beat_cnt), .overflow(overflow));

  nibble_match_scanner #(.WIDTH(4), .IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load2), .key_in(key_in2), .start(start2),
    .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2), .in_ready(in_ready2),
    .busy(busy2), .res_valid(res_valid2), .res_ack(res_ack2), .found(found2),
    .first_idx(first_idx2), .match_cnt(match_cnt2), .beat_cnt(beat_cnt2), .overflow(overflow2));

  int   nvec = 0, nerr = 0;
  exp_t q[$], q2[$];
  bit   seen = 0, seen2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare once per DONE episode.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !seen) begin
      seen = 1;
      if (q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("found", found, e.found);
        chk("first_idx", first_idx, e.first_idx);
        chk("match_cnt", match_cnt, e.match_cnt);
        chk("beat_cnt", beat_cnt, e.beat_cnt);
        chk("overflow", overflow, e.overflow);
      end
    end else if (!res_valid) seen = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (res_valid2 && !seen2) begin
      seen2 = 1;
      if (q2.size() == 0) chk("sb2_unexpected", 1, 0);
      else begin
        e = q2.pop_front();
        chk("found2", found2, e.found);
        chk("first_idx2", first_idx2, e.first_idx);
        chk("match_cnt2", match_cnt2, e.match_cnt);
        chk("beat_cnt2", beat_cnt2, e.beat_cnt);
        chk("overflow2", overflow2, e.overflow);
      end
    end else if (!res_valid2) seen2 = 0;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [3:0] k);
    key_load = 1; key_in = k; cyc(); key_load = 0;
  endtask

  task automatic start_scan(input exp_t e);
    q.push_back(e);
    start = 1; cyc(); start = 0;
    chk("start_busy", {busy, in_ready}, 2'b11);
    chk("start_clear", {found, first_idx, match_cnt, beat_cnt, overflow}, 0);
  endtask

  task automatic beat(input logic [3:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l; cyc();
    in_valid = 0; in_last = 0;
  endtask

  // Holds the result with in_valid=1 (must be ignored), then acks.
  task automatic end_scan(input exp_t e, input logic [3:0] junk);
    int t = 0;
    while (!res_valid && t < 20) begin cyc(); t++; end
    chk("res_valid_timeout", res_valid, 1);
    in_valid = 1; in_data = junk; in_last = 1;
    cyc(); cyc();
    chk("done_hold", res_valid, 1);
    res_ack = 1; cyc(); res_ack = 0; in_valid = 0; in_last = 0;
    chk("ack_idle", {res_valid, busy}, 0);
    chk("idle_results", {found, first_idx, match_cnt, beat_cnt, overflow}, e);
  endtask

  initial begin
    exp_t e;
    rst_n = 0; #12; rst_n = 1; cyc();
    chk("reset_outs", {in_ready, busy, res_valid, found, first_idx, match_cnt, beat_cnt, overflow}, 0);

    // 1: reset mid-scan, then key must read back as 0
    load_key(4'hA);
    start = 1; cyc(); start = 0;
    beat(4'hA, 0); beat(4'hA, 0);
    chk("mid_busy", busy, 1);
    #2 rst_n = 0; #1;
    chk("mid_reset_outs", {in_ready, busy, res_valid, found, first_idx, match_cnt, beat_cnt, overflow}, 0);
    rst_n = 1; cyc();
    e = '{1'b1, 8'd0, 8'd1, 8'd1, 1'b0};
    start_scan(e); beat(4'h0, 1);
    chk("lat_1beat", {res_valid, in_ready}, 2'b10);
    end_scan(e, 4'h0);

    // 2: key 5, stream 3,5,7,5
    load_key(4'h5);
    e = '{1'b1, 8'd1, 8'd2, 8'd4, 1'b0};
    start_scan(e);
    beat(4'h3, 0); beat(4'h5, 0); beat(4'h7, 0);
    chk("no_early_done", res_valid, 0);
    beat(4'h5, 1);
    chk("lat_last", {res_valid, in_ready}, 2'b10);
    end_scan(e, 4'h5);

    // 3: key F, stream 0,1 -> no match
    load_key(4'hF);
    e = '{1'b0, 8'd0, 8'd0, 8'd2, 1'b0};
    start_scan(e);
    beat(4'h0, 0); beat(4'h1, 1);
    end_scan(e, 4'hF);

    // 4: key 0, in_valid toggled; gap cycles carry data 0 but are not beats
    load_key(4'h0);
    e = '{1'b1, 8'd0, 8'd3, 8'd3, 1'b0};
    start_scan(e);
    for (int i = 0; i < 3; i++) begin
      beat(4'h0, i == 2);
      if (i < 2) begin in_data = 4'h0; cyc(); end
    end
    end_scan(e, 4'h0);

    // 6: key_load+start together -> key loaded, stays IDLE; key_load in SCAN ignored
    key_load = 1; key_in = 4'h9; start = 1; cyc(); key_load = 0; start = 0;
    chk("kl_start_idle", {busy, in_ready}, 0);
    e = '{1'b1, 8'd0, 8'd1, 8'd2, 1'b0};
    start_scan(e);
    key_load = 1; key_in = 4'h3; cyc(); key_load = 0;
    beat(4'h9, 0); beat(4'h3, 1);
    end_scan(e, 4'h9);

    // 5: IDX_W=2 saturation on the second instance
    key_load2 = 1; key_in2 = 4'h1; cyc(); key_load2 = 0;
    q2.push_back('{1'b1, 8'd0, 8'd3, 8'd3, 1'b1});
    start2 = 1; cyc(); start2 = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1; in_data2 = 4'h1; in_last2 = (i == 4); cyc();
      in_valid2 = 0; in_last2 = 0;
    end
    begin
      int t = 0;
      while (!res_valid2 && t < 20) begin cyc(); t++; end
      chk("res_valid2_timeout", res_valid2, 1);
    end
    cyc();
    res_ack2 = 1; cyc(); res_ack2 = 0;
    chk("ack2_idle", busy2, 0);

    cyc(); cyc();
    chk("sb_drain", q.size(), 0);
    chk("sb2_drain", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
